// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: opcode classes, 2-bit
// counter encodings, BHT reset value and the flush FSM state type.
package branch_resolve_unit_pkg;

    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'b00,
        CNT_WEAK_NT   = 2'b01,
        CNT_WEAK_T    = 2'b10,
        CNT_STRONG_T  = 2'b11
    } bht_cnt_e;

    localparam logic [1:0] BHT_RESET_VAL = CNT_WEAK_NT;

    typedef enum logic {
        IDLE,
        FLUSHING
    } flush_state_e;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == CNT_STRONG_T) ? cnt : cnt + 2'd1;
        else
            return (cnt == CNT_STRONG_NT) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// bht_2bit: table of 2-bit saturating counters with a combinational lookup
// port and a single registered update port.
module bht_2bit
    import branch_resolve_unit_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             pred_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] table_q [BHT_DEPTH];

    // Lookup reads the registered array, so a same-cycle update is not visible.
    assign pred_taken = table_q[lookup_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++)
                table_q[i] <= BHT_RESET_VAL;
        end else if (upd_en) begin
            table_q[upd_idx] <= sat_update(table_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: detects execute-stage mispredicts, issues a redirect
// and a timed flush, and trains the BHT. Optional BRU_PERF_CNT_EN adds perf counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_DEPTH    = 64,
    parameter int FLUSH_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [31:0]     ex_inst,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] ex_pred_next,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [4:0]      opcode;
    logic            is_jump;
    logic            is_branch;
    logic            resolve;
    logic            mispredict;
    logic [XLEN-1:0] actual_next;

    flush_state_e    state, state_next;
    logic [2:0]      cnt, cnt_next;

    assign opcode      = ex_inst[6:2];
    assign is_jump     = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign is_branch   = (opcode == OP_BRANCH);
    assign actual_next = (is_jump || ex_taken) ? ex_target : ex_pc + XLEN'(4);
    assign resolve     = ex_valid && (is_jump || is_branch) && !flush;
    assign mispredict  = resolve && (actual_next != ex_pred_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            redirect_valid <= mispredict;
            if (mispredict)
                redirect_pc <= actual_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_next = FLUSHING;
                    cnt_next   = 3'(FLUSH_STAGES);
                end
            end
            FLUSHING: begin
                flush = 1'b1;
                if (cnt == 3'd1) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .lookup_idx (if_pc[IDX_W+1:2]),
        .pred_taken (pred_taken),
        .upd_en     (resolve && is_branch),
        .upd_idx    (ex_pc[IDX_W+1:2]),
        .upd_taken  (ex_taken)
    );

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (resolve)
                perf_branches <= perf_branches + 32'd1;
            if (mispredict)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`else
    // Perf counters are not built in this configuration.
`endif

    logic unused_bits;
    assign unused_bits = ^{ex_inst[31:7], ex_inst[1:0], if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: behavioural model compared
// every cycle plus hand-computed directed expectations.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int FS    = 2;

    localparam logic [31:0] I_BRANCH = 32'h0000_0063;
    localparam logic [31:0] I_JAL    = 32'h0000_006F;
    localparam logic [31:0] I_JALR   = 32'h0000_0067;
    localparam logic [31:0] I_ADD    = 32'h0000_0033;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic [31:0]     ex_inst;
    logic [XLEN-1:0] ex_pc, ex_target, ex_pred_next, if_pc;
    logic            ex_taken;
    logic            pred_taken, redirect_valid, flush;
    logic [XLEN-1:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]     perf_branches, perf_mispredicts;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN         (XLEN),
        .BHT_DEPTH    (DEPTH),
        .FLUSH_STAGES (FS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_inst        (ex_inst),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_next   (ex_pred_next),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    // Behavioural model: remaining-flush-cycle count and integer counter table.
    int              m_bht [DEPTH];
    int              m_flush_left;
    bit              m_rv;
    logic [XLEN-1:0] m_rpc;
    longint          m_nbr, m_nmis;

    always @(posedge clk) begin
        if (rst) begin
            m_rv = 1'b0; m_rpc = '0; m_flush_left = 0; m_nbr = 0; m_nmis = 0;
            for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        end else begin
            bit mis;
            int op;
            mis = 1'b0;
            op  = int'(ex_inst[6:2]);
            if (ex_valid && m_flush_left == 0 && (op == 27 || op == 25 || op == 24)) begin
                longint nxt;
                int idx;
                if (op != 24 || ex_taken) nxt = longint'(ex_target);
                else nxt = (longint'(ex_pc) + 4) % (64'd1 << XLEN);
                idx = int'((ex_pc >> 2) % DEPTH);
                if (op == 24) begin
                    if (ex_taken) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
                    else          m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
                end
                mis = (nxt != longint'(ex_pred_next));
                m_nbr++;
                if (mis) begin
                    m_nmis++;
                    m_rpc = XLEN'(nxt);
                end
            end
            m_rv = mis;
            if (mis) m_flush_left = FS;
            else if (m_flush_left > 0) m_flush_left--;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("model redirect_valid", 64'(redirect_valid), 64'(m_rv));
            check("model redirect_pc", 64'(redirect_pc), 64'(m_rpc));
            check("model flush", 64'(flush), 64'(m_flush_left > 0));
            check("model pred_taken", 64'(pred_taken), 64'(m_bht[int'((if_pc >> 2) % DEPTH)] >= 2));
`ifdef BRU_PERF_CNT_EN
            check("model perf_branches", 64'(perf_branches), 64'(m_nbr % (64'd1 << 32)));
            check("model perf_mispredicts", 64'(perf_mispredicts), 64'(m_nmis % (64'd1 << 32)));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic [31:0] pn);
        ex_valid = 1'b1; ex_inst = inst; ex_pc = pc; ex_taken = tk;
        ex_target = tgt; ex_pred_next = pn;
    endtask

    task automatic expect_out(input string tag, input logic rv, input logic [31:0] rpc, input logic fl);
        check({tag, " redirect_valid"}, 64'(redirect_valid), 64'(rv));
        check({tag, " redirect_pc"}, 64'(redirect_pc), 64'(rpc));
        check({tag, " flush"}, 64'(flush), 64'(fl));
    endtask

    task automatic expect_pred(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check({tag, " pred_taken"}, 64'(pred_taken), 64'(exp));
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_inst = I_ADD; ex_pc = '0; ex_taken = 1'b0;
        ex_target = '0; ex_pred_next = '0; if_pc = 32'h100;
        cyc();
        check_en = 1'b1;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        expect_out("reset", 1'b0, 32'h0, 1'b0);
        expect_pred("reset", 32'h100, 1'b0);

        // Taken BRANCH predicted not-taken
        present(I_BRANCH, 32'h40, 1'b1, 32'h80, 32'h44);
        cyc();
        ex_valid = 1'b0;
        expect_out("br mis c1", 1'b1, 32'h80, 1'b1);
        expect_pred("br mis", 32'h40, 1'b1);
        cyc();
        expect_out("br mis c2", 1'b0, 32'h80, 1'b1);
        cyc();
        expect_out("br mis c3", 1'b0, 32'h80, 1'b0);

        // Correctly predicted JALR: no redirect, BHT untouched
        present(I_JALR, 32'h10, 1'b0, 32'h200, 32'h200);
        cyc();
        ex_valid = 1'b0;
        expect_out("jalr ok", 1'b0, 32'h80, 1'b0);
        expect_pred("jalr ok", 32'h10, 1'b0);

        // Non-control-flow opcode is ignored even with wrong pred_next
        present(I_ADD, 32'h14, 1'b1, 32'h999, 32'h0);
        cyc();
        ex_valid = 1'b0;
        expect_out("add ign", 1'b0, 32'h80, 1'b0);

        // JAL mispredict (not-taken ex_taken is irrelevant for jumps)
        present(I_JAL, 32'h20, 1'b0, 32'h300, 32'h24);
        cyc();
        ex_valid = 1'b0;
        expect_out("jal mis", 1'b1, 32'h300, 1'b1);
        cyc(); cyc();
        expect_out("jal done", 1'b0, 32'h300, 1'b0);

        // PC+4 wraps modulo 2^XLEN
        present(I_BRANCH, 32'hFFFF_FFFC, 1'b0, 32'h1234, 32'h100);
        cyc();
        ex_valid = 1'b0;
        expect_out("wrap mis", 1'b1, 32'h0, 1'b1);
        cyc(); cyc();
        present(I_BRANCH, 32'hFFFF_FFFC, 1'b0, 32'h1234, 32'h0);
        cyc();
        ex_valid = 1'b0;
        expect_out("wrap ok", 1'b0, 32'h0, 1'b0);

        // Second mispredict inside the flush window is ignored
        present(I_BRANCH, 32'h60, 1'b1, 32'h500, 32'h64);
        cyc();
        present(I_BRANCH, 32'h60, 1'b0, 32'h700, 32'h900);
        expect_out("dbl c1", 1'b1, 32'h500, 1'b1);
        cyc();
        expect_out("dbl c2", 1'b0, 32'h500, 1'b1);
        cyc();
        ex_valid = 1'b0;
        expect_out("dbl c3", 1'b0, 32'h500, 1'b0);
        expect_pred("dbl", 32'h60, 1'b1);

        // Saturation at 0x40 (entry currently 2): four taken, four not-taken
        for (int i = 0; i < 4; i++) begin
            present(I_BRANCH, 32'h40, 1'b1, 32'h80, 32'h80);
            cyc();
            expect_pred("sat up", 32'h40, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            present(I_BRANCH, 32'h40, 1'b0, 32'h80, 32'h44);
            cyc();
            expect_pred("sat dn", 32'h40, (i == 0) ? 1'b1 : 1'b0);
        end
        ex_valid = 1'b0;
        expect_out("sat", 1'b0, 32'h500, 1'b0);

        // Same-cycle lookup and update returns the pre-update value
        present(I_BRANCH, 32'h40, 1'b1, 32'h80, 32'h80);
        expect_pred("bypass pre", 32'h40, 1'b0);
        cyc();
        present(I_BRANCH, 32'h40, 1'b1, 32'h80, 32'h80);
        expect_pred("bypass mid", 32'h40, 1'b0);
        cyc();
        ex_valid = 1'b0;
        expect_pred("bypass post", 32'h40, 1'b1);

        // Reset in the first flush cycle, with a mispredict presented alongside rst
        present(I_BRANCH, 32'h48, 1'b1, 32'hC0, 32'h4C);
        cyc();
        expect_out("rstfl c1", 1'b1, 32'hC0, 1'b1);
        rst = 1'b1;
        present(I_JAL, 32'h50, 1'b1, 32'hD0, 32'h54);
        cyc();
        rst = 1'b0;
        ex_valid = 1'b0;
        expect_out("rstfl c2", 1'b0, 32'h0, 1'b0);
        expect_pred("rstfl", 32'h40, 1'b0);
`ifdef BRU_PERF_CNT_EN
        check("rstfl perf_branches", 64'(perf_branches), 64'd0);
        check("rstfl perf_mispredicts", 64'(perf_mispredicts), 64'd0);
`endif
        cyc();
        expect_out("post rst", 1'b0, 32'h0, 1'b0);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
